// File: rtl/butterfly_r2_pipe.sv
// Pipelined radix-2 DIT butterfly: y0 = a + b*W, y1 = a - b*W with valid/ready flow
// control, optional conjugate twiddle, per-sample scale-by-1/2 and saturating outputs.
module butterfly_r2_pipe #(
  parameter int WIDTH      = 16,
  parameter int TW_WIDTH   = 16,
  parameter int MUL_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WIDTH-1:0]    a_re,
  input  logic signed [WIDTH-1:0]    a_im,
  input  logic signed [WIDTH-1:0]    b_re,
  input  logic signed [WIDTH-1:0]    b_im,
  input  logic signed [TW_WIDTH-1:0] tw_re,
  input  logic signed [TW_WIDTH-1:0] tw_im,
  input  logic                       scale,
  input  logic                       inverse,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WIDTH-1:0]    y0_re,
  output logic signed [WIDTH-1:0]    y0_im,
  output logic signed [WIDTH-1:0]    y1_re,
  output logic signed [WIDTH-1:0]    y1_im,
  output logic                       out_ovf,
  output logic                       ovf_sticky,
  input  logic                       ovf_clr
);

  localparam int NS = MUL_STAGES;
  localparam int MW = WIDTH + TW_WIDTH;
  localparam int PW = MW + 1;

  localparam logic signed [PW-1:0] P_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] RND   = {{(PW-TW_WIDTH+1){1'b0}}, 1'b1, {(TW_WIDTH-2){1'b0}}};
  localparam logic [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [TW_WIDTH-1:0] TW_MAX = {1'b0, {(TW_WIDTH-1){1'b1}}};
  localparam logic signed [TW_WIDTH-1:0] TW_MIN = {1'b1, {(TW_WIDTH-1){1'b0}}};

  function automatic logic signed [MW-1:0] mul_ext(input logic signed [WIDTH-1:0] x,
                                                   input logic signed [TW_WIDTH-1:0] y);
    logic signed [MW-1:0] xe, ye;
    xe = {{TW_WIDTH{x[WIDTH-1]}}, x};
    ye = {{WIDTH{y[TW_WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  // Half-up rounding back to WIDTH; returns {ovf, value}.
  function automatic logic [WIDTH:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + RND) >>> (TW_WIDTH - 1);
    if (r > P_MAX) return {1'b1, W_MAX};
    if (r < P_MIN) return {1'b1, W_MIN};
    return {1'b0, r[WIDTH-1:0]};
  endfunction

  // Halving always fits; otherwise clip the WIDTH+1 sum.  Returns {ovf, value}.
  function automatic logic [WIDTH:0] finish(input logic signed [WIDTH:0] s, input logic sc);
    logic signed [WIDTH+1:0] t;
    t = {s[WIDTH], s} + {{(WIDTH+1){1'b0}}, 1'b1};
    if (sc) return {1'b0, t[WIDTH:1]};
    if (s[WIDTH] != s[WIDTH-1]) return {1'b1, (s[WIDTH] ? W_MIN : W_MAX)};
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  logic                       adv;
  logic signed [TW_WIDTH-1:0] tw_im_eff;
  logic signed [MW-1:0]       pm_rr, pm_ii, pm_ri, pm_ir;
  logic signed [PW-1:0]       p_re, p_im;

  logic [NS-1:0]              vld;
  logic [NS-1:0]              scale_q;
  logic signed [WIDTH-1:0]    a_re_q [NS];
  logic signed [WIDTH-1:0]    a_im_q [NS];
  logic signed [PW-1:0]       pr_q   [NS];
  logic signed [PW-1:0]       pi_q   [NS];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    tw_im_eff = tw_im;
    if (inverse) tw_im_eff = (tw_im == TW_MIN) ? TW_MAX : -tw_im;
  end

  assign pm_rr = mul_ext(b_re, tw_re);
  assign pm_ii = mul_ext(b_im, tw_im_eff);
  assign pm_ri = mul_ext(b_re, tw_im_eff);
  assign pm_ir = mul_ext(b_im, tw_re);
  assign p_re  = {pm_rr[MW-1], pm_rr} - {pm_ii[MW-1], pm_ii};
  assign p_im  = {pm_ri[MW-1], pm_ri} + {pm_ir[MW-1], pm_ir};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      scale_q <= '0;
      for (int i = 0; i < NS; i++) begin
        a_re_q[i] <= '0;
        a_im_q[i] <= '0;
        pr_q[i]   <= '0;
        pi_q[i]   <= '0;
      end
    end else if (adv) begin
      vld[0]     <= in_valid;
      scale_q[0] <= scale;
      a_re_q[0]  <= a_re;
      a_im_q[0]  <= a_im;
      pr_q[0]    <= p_re;
      pi_q[0]    <= p_im;
      for (int i = 1; i < NS; i++) begin
        vld[i]     <= vld[i-1];
        scale_q[i] <= scale_q[i-1];
        a_re_q[i]  <= a_re_q[i-1];
        a_im_q[i]  <= a_im_q[i-1];
        pr_q[i]    <= pr_q[i-1];
        pi_q[i]    <= pi_q[i-1];
      end
    end
  end

  logic [WIDTH:0]          bw_re_s, bw_im_s;
  logic signed [WIDTH-1:0] bw_re, bw_im, a_re_l, a_im_l;
  logic signed [WIDTH:0]   s0_re, s0_im, s1_re, s1_im;
  logic [WIDTH:0]          f0_re, f0_im, f1_re, f1_im;
  logic                    ovf_any;

  assign bw_re_s = round_sat(pr_q[NS-1]);
  assign bw_im_s = round_sat(pi_q[NS-1]);
  assign bw_re   = bw_re_s[WIDTH-1:0];
  assign bw_im   = bw_im_s[WIDTH-1:0];
  assign a_re_l  = a_re_q[NS-1];
  assign a_im_l  = a_im_q[NS-1];

  assign s0_re = {a_re_l[WIDTH-1], a_re_l} + {bw_re[WIDTH-1], bw_re};
  assign s0_im = {a_im_l[WIDTH-1], a_im_l} + {bw_im[WIDTH-1], bw_im};
  assign s1_re = {a_re_l[WIDTH-1], a_re_l} - {bw_re[WIDTH-1], bw_re};
  assign s1_im = {a_im_l[WIDTH-1], a_im_l} - {bw_im[WIDTH-1], bw_im};

  assign f0_re = finish(s0_re, scale_q[NS-1]);
  assign f0_im = finish(s0_im, scale_q[NS-1]);
  assign f1_re = finish(s1_re, scale_q[NS-1]);
  assign f1_im = finish(s1_im, scale_q[NS-1]);

  assign ovf_any = bw_re_s[WIDTH] | bw_im_s[WIDTH] | f0_re[WIDTH] | f0_im[WIDTH]
                 | f1_re[WIDTH] | f1_im[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
      y0_re     <= '0;
      y0_im     <= '0;
      y1_re     <= '0;
      y1_im     <= '0;
    end else if (adv) begin
      out_valid <= vld[NS-1];
      out_ovf   <= ovf_any;
      y0_re     <= f0_re[WIDTH-1:0];
      y0_im     <= f0_im[WIDTH-1:0];
      y1_re     <= f1_re[WIDTH-1:0];
      y1_im     <= f1_im[WIDTH-1:0];
    end
  end

  // A flagged sample leaving the block outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && out_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)                          ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Bench for butterfly_r2_pipe: vector table and random stream checked through an
// in-order scoreboard, plus latency, stall, sticky-flag and mid-stream reset sequences.
module tb_butterfly_r2_pipe;

  logic clk, rst_n, in_valid, in_ready, scale, inverse, out_valid, out_ready;
  logic out_ovf, ovf_sticky, ovf_clr;
  logic signed [15:0] a_re, a_im, b_re, b_im, tw_re, tw_im;
  logic signed [15:0] y0_re, y0_im, y1_re, y1_im;

  butterfly_r2_pipe #(.WIDTH(16), .TW_WIDTH(16), .MUL_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tw_re(tw_re), .tw_im(tw_im),
    .scale(scale), .inverse(inverse), .out_valid(out_valid), .out_ready(out_ready),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
    .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [15:0] y0re, y0im, y1re, y1im;
    logic               ovf;
  } exp_t;

  typedef struct packed {
    logic signed [15:0] a_re, a_im, b_re, b_im, tw_re, tw_im;
    logic               scale, inverse;
    exp_t               e;
  } vec_t;

  exp_t q[$];
  exp_t got;
  vec_t tbl[9];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_rdy = 0;
  bit   stall_prev = 0;
  logic [63:0] held;

  function automatic vec_t mkv(input int ar, ai, br, bi, tr, ti, input bit sc, inv,
                               input int y0r, y0i, y1r, y1i, input bit o);
    vec_t v;
    v.a_re = 16'(ar); v.a_im = 16'(ai); v.b_re = 16'(br); v.b_im = 16'(bi);
    v.tw_re = 16'(tr); v.tw_im = 16'(ti); v.scale = sc; v.inverse = inv;
    v.e.y0re = 16'(y0r); v.e.y0im = 16'(y0i); v.e.y1re = 16'(y1r); v.e.y1im = 16'(y1i);
    v.e.ovf = o;
    return v;
  endfunction

  function automatic longint rnd_sat(input longint p, inout bit o);
    longint r;
    r = (p + 64'sd16384) >>> 15;
    if (r > 32767)  begin o = 1; return 32767; end
    if (r < -32768) begin o = 1; return -32768; end
    return r;
  endfunction

  function automatic logic signed [15:0] fin(input longint s, input bit sc, inout bit o);
    if (sc) return 16'((s + 1) >>> 1);
    if (s > 32767)  begin o = 1; return 16'sh7fff; end
    if (s < -32768) begin o = 1; return 16'sh8000; end
    return 16'(s);
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t   e;
    bit     o;
    longint twi, pr, pi, ar, ai;
    o   = 0;
    twi = longint'($signed(v.tw_im));
    if (v.inverse) twi = (twi == -32768) ? 32767 : -twi;
    pr = longint'($signed(v.b_re)) * longint'($signed(v.tw_re)) - longint'($signed(v.b_im)) * twi;
    pi = longint'($signed(v.b_re)) * twi + longint'($signed(v.b_im)) * longint'($signed(v.tw_re));
    pr = rnd_sat(pr, o);
    pi = rnd_sat(pi, o);
    ar = longint'($signed(v.a_re));
    ai = longint'($signed(v.a_im));
    e.y0re = fin(ar + pr, v.scale, o);
    e.y0im = fin(ai + pi, v.scale, o);
    e.y1re = fin(ar - pr, v.scale, o);
    e.y1im = fin(ai - pi, v.scale, o);
    e.ovf  = o;
    return e;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  // Leaves in_valid high so successive calls stream back to back.
  task automatic send(input vec_t v);
    bit ok;
    ok = 0;
    a_re = v.a_re; a_im = v.a_im; b_re = v.b_re; b_im = v.b_im;
    tw_re = v.tw_re; tw_im = v.tw_im; scale = v.scale; inverse = v.inverse;
    in_valid = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready never rose");
    end else begin
      q.push_back(v.e);
      tick();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 1000; k++) begin
      if (q.size() == 0) break;
      tick();
    end
    check("drain_empty", q.size(), 0);
    tick();
  endtask

  task automatic wait_out_valid(input string nm);
    bit seen;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin seen = 1; break; end
      tick();
    end
    check(nm, seen, 1);
  endtask

  // Scoreboard monitor: transfers are judged on the falling edge ahead of their clock edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        n_cmp++;
        if (!out_valid || {y0_re, y0_im, y1_re, y1_im} != held) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%0b y=%h expected valid=1 y=%h",
                   out_valid, {y0_re, y0_im, y1_re, y1_im}, held);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got y=%h with no sample outstanding",
                   {y0_re, y0_im, y1_re, y1_im});
        end else begin
          got = q.pop_front();
          if ({y0_re, y0_im, y1_re, y1_im, out_ovf} != got) begin
            n_err++;
            $display("FAIL sample: got y0=(%0d,%0d) y1=(%0d,%0d) ovf=%0b expected y0=(%0d,%0d) y1=(%0d,%0d) ovf=%0b",
                     y0_re, y0_im, y1_re, y1_im, out_ovf,
                     got.y0re, got.y0im, got.y1re, got.y1im, got.ovf);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {y0_re, y0_im, y1_re, y1_im};
    end
  end

  initial begin
    #300000;
    n_err++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    bit   seen;
    vec_t v;

    rst_n = 0; in_valid = 0; scale = 0; inverse = 0; out_ready = 1; ovf_clr = 0;
    a_re = 0; a_im = 0; b_re = 0; b_im = 0; tw_re = 0; tw_im = 0;

    tbl[0] = mkv(1000, 0, 500, 0, 32767, 0, 0, 0,   1500, 0, 500, 0, 0);
    tbl[1] = mkv(0, 0, 0, 1000, 0, 32767, 0, 0,     -1000, 0, 1000, 0, 0);
    tbl[2] = mkv(0, 0, 0, 1000, 0, 32767, 0, 1,     1000, 0, -1000, 0, 0);
    tbl[3] = mkv(30000, 0, 10000, 0, 32767, 0, 0, 0, 32767, 0, 20000, 0, 1);
    tbl[4] = mkv(30000, 0, 10000, 0, 32767, 0, 1, 0, 20000, 0, 10000, 0, 0);
    tbl[5] = mkv(0, 0, -32768, 0, -32768, 0, 0, 0,  32767, 0, -32767, 0, 1);
    tbl[6] = mkv(0, 0, -32768, 0, 0, -32768, 0, 1,  0, -32767, 0, 32767, 0);
    tbl[7] = mkv(-3, 5, 0, 0, 32767, 0, 1, 0,       -1, 3, -1, 3, 0);
    tbl[8] = mkv(0, -30000, 0, -10000, 32767, 0, 0, 0, 0, -32768, 0, -20000, 1);

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_sticky", ovf_sticky, 0);
    check("rst_y0_re", y0_re, 0);
    check("rst_y1_im", y1_im, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    send(tbl[0]);
    in_valid = 0;
    n = 1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) break;
      tick();
      n++;
    end
    check("latency", n, 3);
    drain();

    for (int i = 0; i < 9; i++) send(tbl[i]);
    in_valid = 0;
    drain();
    check("sticky_set", ovf_sticky, 1);

    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    check("sticky_clr", ovf_sticky, 0);

    ovf_clr = 1;
    send(tbl[5]);
    in_valid = 0;
    wait_out_valid("set_wins_out_valid");
    tick();
    check("sticky_set_wins", ovf_sticky, 1);
    ovf_clr = 0;
    drain();

    send(tbl[1]);
    in_valid = 0;
    out_ready = 0;
    wait_out_valid("stall_out_valid");
    check("in_ready_stall", in_ready, 0);
    tick(); tick(); tick();
    out_ready = 1;
    drain();

    rand_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      v = mkv($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
      v.e = model(v);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 0;
        tick();
      end
      send(v);
    end
    in_valid = 0;
    drain();
    rand_rdy = 0;
    out_ready = 1;
    tick();

    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    send(tbl[3]);
    in_valid = 0;
    drain();
    check("sticky_pre_reset", ovf_sticky, 1);
    send(tbl[0]);
    send(tbl[1]);
    in_valid = 0;
    rst_n = 0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sticky", ovf_sticky, 0);
    q.delete();
    tick(); tick();
    rst_n = 1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("no_stale_output", seen, 0);

    send(tbl[2]);
    in_valid = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
